config_shadow_chain: RTL and testbench

CONFIG_SHADOW_CHAIN -- requirements
Module: config_shadow_chain

---
 rtl/config_pkg.sv | 40 ++++
 rtl/config_xor_accum.sv | 37 +++
 rtl/config_shadow_chain.sv | 185 ++++++++++++++++++
 tb/tb_config_shadow_chain.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// ---------------------------------------------------------------------------
// config_pkg
// Shared definitions for the configuration shadow chain:
//   - cfg_state_t : FSM state encoding (IDLE, LOAD, WAIT_IDLE, COMMIT)
//   - N_PE        : default channel count used by the top-level parameter
//   - n_cfg()     : number of payload config words
//   - n_reg()     : number of chain words (payload plus optional checksum)
//   - chain_idx() : chain position of a per-channel word
// Optional feature macro: CONFIG_CHECKSUM_EN (adds one checksum word).
// ---------------------------------------------------------------------------
package config_pkg;

    localparam int N_PE = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_IDLE = 2'd2,
        ST_COMMIT    = 2'd3
    } cfg_state_t;

    function automatic int n_cfg(input int n_ch, input int words_per_ch, input int n_global);
        return n_ch * words_per_ch + n_global;
    endfunction

    // With the checksum option, the trailing checksum word occupies one
    // extra chain slot in front of the payload.
    function automatic int n_reg(input int num_cfg);
`ifdef CONFIG_CHECKSUM_EN
        return num_cfg + 1;
`else
        return num_cfg;
`endif
    endfunction

    function automatic int chain_idx(input int ch, input int w, input int words_per_ch);
        return ch * words_per_ch + w;
    endfunction

endpackage

// File: rtl/config_xor_accum.sv
// ---------------------------------------------------------------------------
// config_xor_accum
// Running XOR of every word shifted into the config chain. A load whose
// words (payload plus checksum) XOR to zero is considered intact.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart accumulation (first word of a new load)
//   enable   : a word is being shifted this cycle
//   data     : the word being shifted
//   acc      : current accumulator value
// ---------------------------------------------------------------------------
module config_xor_accum
    import config_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] data,
    output logic [W-1:0] acc
);

    // Clearing and accumulating in the same cycle means the first word of
    // the new load becomes the accumulator seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= enable ? data : '0;
        end else if (enable) begin
            acc <= acc ^ data;
        end
    end

endmodule

// File: rtl/config_shadow_chain.sv
// ---------------------------------------------------------------------------
// config_shadow_chain
// Serial configuration shift chain with shadowed active registers. Words are
// shifted in, then a commit request copies the chain into the active
// registers once the datapath reports it is idle.
// Optional feature macro: CONFIG_CHECKSUM_EN -- the last word shifted is an
// XOR checksum; a commit is accepted only if all shifted words XOR to 0.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   shift_en    : shift data_in into chain word 0
//   data_in     : serial config word
//   data_out    : last chain word (daisy-chain output)
//   commit_req  : request copy of chain into active registers
//   core_idle   : datapath quiescent, active config may change
//   busy        : commit pending (WAIT_IDLE or COMMIT)
//   commit_ack  : one-cycle pulse when new active values appear
//   cfg_err     : sticky failed-commit flag
//   cfg_valid   : at least one commit accepted since reset
//   ch_cfg      : active per-channel words [ch][w]
//   glb_cfg     : active global words [g]
// ---------------------------------------------------------------------------
module config_shadow_chain
    import config_pkg::*;
#(
    parameter int CONFIG_L     = 32,
    parameter int N_CH         = N_PE,
    parameter int WORDS_PER_CH = 6,
    parameter int N_GLOBAL     = 21
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           shift_en,
    input  logic [CONFIG_L-1:0]                            data_in,
    output logic [CONFIG_L-1:0]                            data_out,
    input  logic                                           commit_req,
    input  logic                                           core_idle,
    output logic                                           busy,
    output logic                                           commit_ack,
    output logic                                           cfg_err,
    output logic                                           cfg_valid,
    output logic [N_CH-1:0][WORDS_PER_CH-1:0][CONFIG_L-1:0] ch_cfg,
    output logic [N_GLOBAL-1:0][CONFIG_L-1:0]              glb_cfg
);

    localparam int N_CFG = n_cfg(N_CH, WORDS_PER_CH, N_GLOBAL);
    localparam int N_REG = n_reg(N_CFG);
    localparam int CNT_W = $clog2(N_REG + 2);
    // Payload starts after the checksum slot when the checksum is present.
    localparam int OFS   = N_REG - N_CFG;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_REG);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(N_REG + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    cfg_state_t state, state_next;

    logic [N_REG-1:0][CONFIG_L-1:0] chain;
    logic [CNT_W-1:0]               word_cnt, cnt_next;
    logic                           do_shift;
    logic                           do_commit;
    logic                           set_err;
    logic                           chk_ok;

`ifdef CONFIG_CHECKSUM_EN
    logic [CONFIG_L-1:0] chk_acc;
    logic                acc_clear;

    // A shift out of IDLE starts a fresh load, so the accumulator restarts.
    assign acc_clear = (state == ST_IDLE) && shift_en;

    config_xor_accum #(
        .W(CONFIG_L)
    ) u_xor_accum (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .enable(do_shift),
        .data  (data_in),
        .acc   (chk_acc)
    );

    assign chk_ok = (chk_acc == '0);
`else
    assign chk_ok = 1'b1;
`endif

    assign data_out = chain[N_REG-1];
    assign busy     = (state == ST_WAIT_IDLE) || (state == ST_COMMIT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode. A shift always wins over a commit
    // request arriving in the same cycle; both are ignored while a commit
    // is pending so the chain cannot change under the copy.
    always_comb begin
        state_next = state;
        cnt_next   = word_cnt;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (shift_en) begin
                    do_shift   = 1'b1;
                    cnt_next   = CNT_ONE;
                    state_next = ST_LOAD;
                end else if (commit_req) begin
                    set_err = 1'b1;
                end
            end
            ST_LOAD: begin
                if (shift_en) begin
                    do_shift = 1'b1;
                    cnt_next = (word_cnt == CNT_SAT) ? CNT_SAT : word_cnt + CNT_ONE;
                end else if (commit_req) begin
                    if ((word_cnt == CNT_FULL) && chk_ok) begin
                        state_next = ST_WAIT_IDLE;
                    end else begin
                        set_err    = 1'b1;
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (core_idle) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                do_commit  = 1'b1;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Chain, counter, status flags and the active shadow registers.
    // commit_ack is registered together with the shadow copy so the pulse
    // lines up with the first cycle the new values are visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain      <= '0;
            word_cnt   <= '0;
            cfg_err    <= 1'b0;
            cfg_valid  <= 1'b0;
            commit_ack <= 1'b0;
            ch_cfg     <= '0;
            glb_cfg    <= '0;
        end else begin
            commit_ack <= do_commit;
            word_cnt   <= cnt_next;
            if (do_shift) begin
                chain <= {chain[N_REG-2:0], data_in};
            end
            if (set_err) begin
                cfg_err <= 1'b1;
            end else if (do_commit) begin
                cfg_err <= 1'b0;
            end
            if (do_commit) begin
                cfg_valid <= 1'b1;
                for (int c = 0; c < N_CH; c++) begin
                    for (int w = 0; w < WORDS_PER_CH; w++) begin
                        ch_cfg[c][w] <= chain[chain_idx(c, w, WORDS_PER_CH) + OFS];
                    end
                end
                for (int g = 0; g < N_GLOBAL; g++) begin
                    glb_cfg[g] <= chain[N_CH * WORDS_PER_CH + g + OFS];
                end
            end
        end
    end

endmodule

// File: tb/tb_config_shadow_chain.sv
// ---------------------------------------------------------------------------
// tb_config_shadow_chain
// Self-checking bench for config_shadow_chain (N_CH=2, WORDS_PER_CH=2,
// N_GLOBAL=1, CONFIG_L=8). A behavioural model keeps the shifted words in a
// queue and tracks the commit handshake; every cycle the DUT outputs are
// compared against it. Builds with or without CONFIG_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_config_shadow_chain;
    import config_pkg::*;

    localparam int CL    = 8;
    localparam int NCH   = 2;
    localparam int WPC   = 2;
    localparam int NG    = 1;
    localparam int N_CFG = n_cfg(NCH, WPC, NG);
    localparam int N_REG = n_reg(N_CFG);
    localparam int OFS   = N_REG - N_CFG;

    logic                               clk;
    logic                               rst;
    logic                               shift_en;
    logic [CL-1:0]                      data_in;
    logic [CL-1:0]                      data_out;
    logic                               commit_req;
    logic                               core_idle;
    logic                               busy;
    logic                               commit_ack;
    logic                               cfg_err;
    logic                               cfg_valid;
    logic [NCH-1:0][WPC-1:0][CL-1:0]    ch_cfg;
    logic [NG-1:0][CL-1:0]              glb_cfg;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state.
    logic [CL-1:0] m_chain[$];
    logic [CL-1:0] m_active[N_CFG];
    logic [CL-1:0] m_acc;
    int            m_cnt;
    bit            m_loading;
    int            m_pending;
    bit            m_err, m_valid, m_ack;

    config_shadow_chain #(
        .CONFIG_L    (CL),
        .N_CH        (NCH),
        .WORDS_PER_CH(WPC),
        .N_GLOBAL    (NG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .commit_req(commit_req),
        .core_idle (core_idle),
        .busy      (busy),
        .commit_ack(commit_ack),
        .cfg_err   (cfg_err),
        .cfg_valid (cfg_valid),
        .ch_cfg    (ch_cfg),
        .glb_cfg   (glb_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_chain.delete();
        for (int i = 0; i < N_REG; i++) m_chain.push_back('0);
        for (int i = 0; i < N_CFG; i++) m_active[i] = '0;
        m_acc     = '0;
        m_cnt     = 0;
        m_loading = 0;
        m_pending = 0;
        m_err     = 0;
        m_valid   = 0;
        m_ack     = 0;
    endtask

    // m_pending: 0 = no commit pending, 1 = accepted and waiting for idle,
    // 2 = copy happens at this edge.
    task automatic modelStep(input bit sh, input logic [CL-1:0] d, input bit cm, input bit idl);
        m_ack = 0;
        if (m_pending == 2) begin
            for (int i = 0; i < N_CFG; i++) m_active[i] = m_chain[i + OFS];
            m_ack     = 1;
            m_valid   = 1;
            m_err     = 0;
            m_cnt     = 0;
            m_loading = 0;
            m_pending = 0;
        end else if (m_pending == 1) begin
            if (idl) m_pending = 2;
        end else if (sh) begin
            if (!m_loading) begin
                m_loading = 1;
                m_cnt     = 1;
                m_acc     = d;
            end else begin
                m_cnt = (m_cnt + 1 > N_REG + 1) ? N_REG + 1 : m_cnt + 1;
                m_acc = m_acc ^ d;
            end
            m_chain.push_front(d);
            void'(m_chain.pop_back());
        end else if (cm) begin
            if (m_loading && m_cnt == N_REG && (OFS == 0 || m_acc == '0)) begin
                m_pending = 1;
            end else begin
                m_err = 1;
                m_loading = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic checkAll();
        logic [63:0] exp_act;
        exp_act = '0;
        for (int i = 0; i < N_CFG; i++) exp_act[i*CL +: CL] = m_active[i];
        checkOutput("data_out", 64'(data_out), 64'(m_chain[N_REG-1]));
        checkOutput("busy", 64'(busy), 64'(m_pending != 0));
        checkOutput("commit_ack", 64'(commit_ack), 64'(m_ack));
        checkOutput("cfg_err", 64'(cfg_err), 64'(m_err));
        checkOutput("cfg_valid", 64'(cfg_valid), 64'(m_valid));
        checkOutput("active", 64'({glb_cfg, ch_cfg}), exp_act);
    endtask

    task automatic applyStimulus(input bit sh, input logic [CL-1:0] d, input bit cm, input bit idl);
        shift_en   = sh;
        data_in    = d;
        commit_req = cm;
        core_idle  = idl;
        @(posedge clk);
        modelStep(sh, d, cm, idl);
        #1;
        checkAll();
    endtask

    // Shifts n_payload words (base+i, or random when base is 0), followed by
    // a checksum word in checksum builds; chk_flip corrupts that checksum.
    task automatic shiftFrame(input int n_payload, input int base, input logic [CL-1:0] chk_flip,
                              input bit commit_on_last);
        logic [CL-1:0] frame[$];
        logic [CL-1:0] x;
        logic [CL-1:0] w;
        x = '0;
        for (int i = 0; i < n_payload; i++) begin
            w = (base != 0) ? CL'(base + i) : CL'($urandom);
            frame.push_back(w);
            x = x ^ w;
        end
        if (OFS == 1) frame.push_back(x ^ chk_flip);
        for (int i = 0; i < frame.size(); i++) begin
            applyStimulus(1'b1, frame[i], commit_on_last && (i == frame.size() - 1), 1'b1);
        end
    endtask

    task automatic waitAck(input int max_cycles, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            applyStimulus(1'b0, CL'($urandom), 1'b0, 1'b1);
            if (commit_ack) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) checkOutput("ack_timeout", 64'(commit_ack), 64'd1);
    endtask

    initial begin
        int lat;
        logic [63:0] saved_act;
        logic [CL-1:0] hold;

        rst        = 1'b1;
        shift_en   = 1'b0;
        data_in    = '0;
        commit_req = 1'b0;
        core_idle  = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkAll();

        // Basic commit with known words.
        shiftFrame(N_CFG, 8'h11, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        waitAck(20, lat);
        checkOutput("basic_latency", 64'(lat + 1), 64'd3);
        checkOutput("basic_glb0", 64'(glb_cfg[0]), 64'h11);
        checkOutput("basic_ch11", 64'(ch_cfg[1][1]), 64'h12);
        checkOutput("basic_ch00", 64'(ch_cfg[0][0]), 64'h15);
        checkOutput("basic_valid", 64'(cfg_valid), 64'd1);

        // Short load is rejected and leaves the active values alone.
        saved_act = 64'({glb_cfg, ch_cfg});
        shiftFrame(N_CFG - 1, 0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("short_err", 64'(cfg_err), 64'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
            checkOutput("short_no_ack", 64'(commit_ack), 64'd0);
        end
        checkOutput("short_active", 64'({glb_cfg, ch_cfg}), saved_act);

        // Commit held off by a busy datapath; shifts are ignored meanwhile.
        shiftFrame(N_CFG, 0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        hold = data_out;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), CL'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            checkOutput("gate_busy", 64'(busy), 64'd1);
            checkOutput("gate_dout", 64'(data_out), 64'(hold));
        end
        waitAck(20, lat);
        checkOutput("gate_latency", 64'(lat), 64'd2);

        // Commit request coinciding with the last shift is ignored.
        shiftFrame(N_CFG, 0, 8'h00, 1'b1);
        checkOutput("same_no_err", 64'(cfg_err), 64'd0);
        checkOutput("same_no_busy", 64'(busy), 64'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        waitAck(20, lat);

        // One word too many is rejected.
        shiftFrame(N_CFG + 1, 0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("over_err", 64'(cfg_err), 64'd1);

`ifdef CONFIG_CHECKSUM_EN
        // Payload 0x01..0x05 with checksum 0x01, then with checksum 0x00.
        shiftFrame(N_CFG, 1, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("chk_good_busy", 64'(busy), 64'd1);
        waitAck(20, lat);
        checkOutput("chk_good_err", 64'(cfg_err), 64'd0);
        shiftFrame(N_CFG, 1, 8'h01, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("chk_bad_err", 64'(cfg_err), 64'd1);
`endif

        // Reset while waiting for idle aborts the commit.
        shiftFrame(N_CFG, 0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rst_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        modelReset();
        #2;
        checkAll();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
            checkOutput("rst_no_ack", 64'(commit_ack), 64'd0);
        end

        // Random full frames, some with a corrupted checksum.
        for (int f = 0; f < 15; f++) begin
            shiftFrame(N_CFG + (($urandom_range(0, 3) == 0) ? 1 : 0), 0,
                       ($urandom_range(0, 3) == 0) ? 8'h04 : 8'h00, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b1, 1'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                applyStimulus(1'b0, CL'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        end

        // Free-running random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 50), CL'($urandom),
                          1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 70));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
